// File: rtl/complex_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// complex_multiplier_pkg
//   Shared widths for the complex multiplier and its Vedic multiplier core.
//   OPERAND_W : width of each real/imaginary operand component
//   PRODUCT_W : width of each exact partial product and of each result part
// ---------------------------------------------------------------------------
package complex_multiplier_pkg;

    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;

endpackage

// File: rtl/complex_multiplier_vedic_mul32.sv
// ---------------------------------------------------------------------------
// vedic_mul32 and its building blocks
//   Exact 32x32 unsigned multiplier built as a Urdhva-Tiryagbhyam tree:
//   256 2x2 leaf blocks are merged level by level (4x4, 8x8, 16x16, 32x32),
//   each merge combining four half-width products with carry-select adders.
//
//   vedic_cs_adder : W-bit carry-select adder, sum mod 2^W
//       a, b   in  [W-1:0]
//       sum    out [W-1:0]
//   vedic_2x2      : 2x2 leaf multiplier
//       a, b   in  [1:0]
//       p      out [3:0]
//   vedic_combine  : merges four NxN products into one 2Nx2N product
//       ll, hl, lh, hh in [2N-1:0]  (ll = a_lo*b_lo, hl = a_hi*b_lo, ...)
//       prod           out [4N-1:0]
//   vedic_mul32    : top of the tree
//       a, b   in  [OPERAND_W-1:0]
//       p      out [PRODUCT_W-1:0]
// ---------------------------------------------------------------------------

module vedic_cs_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0]   lo_sum;
    logic [HI-1:0] hi_sum0;
    logic [HI-1:0] hi_sum1;

    // Upper half is precomputed for both carry-in values; the carry out of
    // the lower half just picks one. Carry out of the MSB is dropped.
    always_comb begin
        lo_sum  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};
        hi_sum0 = a[W-1:LO] + b[W-1:LO];
        hi_sum1 = a[W-1:LO] + b[W-1:LO] + HI'(1);
        sum     = lo_sum[LO] ? {hi_sum1, lo_sum[LO-1:0]}
                             : {hi_sum0, lo_sum[LO-1:0]};
    end
endmodule

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t_cross0;
    logic t_cross1;
    logic t_high;
    logic c_mid;

    // Vertical (a0b0), crosswise (a1b0 + a0b1) and vertical (a1b1) terms.
    always_comb begin
        t_cross0 = a[1] & b[0];
        t_cross1 = a[0] & b[1];
        t_high   = a[1] & b[1];
        c_mid    = t_cross0 & t_cross1;
        p[0]     = a[0] & b[0];
        p[1]     = t_cross0 ^ t_cross1;
        p[2]     = t_high ^ c_mid;
        p[3]     = t_high & c_mid;
    end
endmodule

module vedic_combine #(
    parameter int N = 2
) (
    input  logic [2*N-1:0] ll,
    input  logic [2*N-1:0] hl,
    input  logic [2*N-1:0] lh,
    input  logic [2*N-1:0] hh,
    output logic [4*N-1:0] prod
);
    logic [2*N:0]   mid;
    logic [3*N-1:0] upper;

    // prod = ll + (hl + lh) << N + hh << 2N. The low N bits of ll pass
    // straight through; everything above bit N is one 3N-bit addition,
    // which cannot overflow because the full product fits in 4N bits.
    vedic_cs_adder #(.W(2*N+1)) u_mid (
        .a   ({1'b0, hl}),
        .b   ({1'b0, lh}),
        .sum (mid)
    );

    vedic_cs_adder #(.W(3*N)) u_upper (
        .a   ({hh, ll[2*N-1:N]}),
        .b   ({{(N-1){1'b0}}, mid}),
        .sum (upper)
    );

    assign prod = {upper, ll[N-1:0]};
endmodule

module vedic_mul32
    import complex_multiplier_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [PRODUCT_W-1:0] p
);
    // pX[i][j] is the product of operand-a block i and operand-b block j,
    // where blocks are X/2 bits wide.
    logic [3:0]  p4  [16][16];
    logic [7:0]  p8  [8][8];
    logic [15:0] p16 [4][4];
    logic [31:0] p32 [2][2];

    for (genvar i = 0; i < 16; i++) begin : g_l1_row
        for (genvar j = 0; j < 16; j++) begin : g_l1_col
            vedic_2x2 u_blk (
                .a (a[2*i +: 2]),
                .b (b[2*j +: 2]),
                .p (p4[i][j])
            );
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_l2_row
        for (genvar j = 0; j < 8; j++) begin : g_l2_col
            vedic_combine #(.N(2)) u_blk (
                .ll   (p4[2*i][2*j]),
                .hl   (p4[2*i+1][2*j]),
                .lh   (p4[2*i][2*j+1]),
                .hh   (p4[2*i+1][2*j+1]),
                .prod (p8[i][j])
            );
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_l3_row
        for (genvar j = 0; j < 4; j++) begin : g_l3_col
            vedic_combine #(.N(4)) u_blk (
                .ll   (p8[2*i][2*j]),
                .hl   (p8[2*i+1][2*j]),
                .lh   (p8[2*i][2*j+1]),
                .hh   (p8[2*i+1][2*j+1]),
                .prod (p16[i][j])
            );
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_l4_row
        for (genvar j = 0; j < 2; j++) begin : g_l4_col
            vedic_combine #(.N(8)) u_blk (
                .ll   (p16[2*i][2*j]),
                .hl   (p16[2*i+1][2*j]),
                .lh   (p16[2*i][2*j+1]),
                .hh   (p16[2*i+1][2*j+1]),
                .prod (p32[i][j])
            );
        end
    end

    vedic_combine #(.N(16)) u_top (
        .ll   (p32[0][0]),
        .hl   (p32[1][0]),
        .lh   (p32[0][1]),
        .hh   (p32[1][1]),
        .prod (p)
    );
endmodule

// File: rtl/complex_multiplier.sv
// ---------------------------------------------------------------------------
// complex_multiplier
//   (ar + j*ai) * (br + j*bi) on unsigned 32-bit components, results wrapped
//   to 64 bits, one-cycle latency, one pair per clock.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   ar/ai/br/bi carry an operand pair this cycle
//   ar, ai     in   [31:0] operand A real / imaginary
//   br, bi     in   [31:0] operand B real / imaginary
//   pr, pi     out  [63:0] registered product real / imaginary
//   out_valid  out  high for the cycle pr/pi hold a fresh result
// ---------------------------------------------------------------------------
module complex_multiplier
    import complex_multiplier_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [OPERAND_W-1:0] ar,
    input  logic [OPERAND_W-1:0] ai,
    input  logic [OPERAND_W-1:0] br,
    input  logic [OPERAND_W-1:0] bi,
    output logic [PRODUCT_W-1:0] pr,
    output logic [PRODUCT_W-1:0] pi,
    output logic                 out_valid
);
    logic [PRODUCT_W-1:0] ar_br;
    logic [PRODUCT_W-1:0] ai_bi;
    logic [PRODUCT_W-1:0] ar_bi;
    logic [PRODUCT_W-1:0] ai_br;
    logic [PRODUCT_W-1:0] real_diff;
    logic [PRODUCT_W-1:0] imag_sum;

    logic [PRODUCT_W-1:0] pr_d, pr_q;
    logic [PRODUCT_W-1:0] pi_d, pi_q;
    logic                 out_valid_d, out_valid_q;

    vedic_mul32 u_mul_ar_br (.a(ar), .b(br), .p(ar_br));
    vedic_mul32 u_mul_ai_bi (.a(ai), .b(bi), .p(ai_bi));
    vedic_mul32 u_mul_ar_bi (.a(ar), .b(bi), .p(ar_bi));
    vedic_mul32 u_mul_ai_br (.a(ai), .b(br), .p(ai_br));

    // Both operations wrap mod 2^64: the borrow / carry out is discarded.
    assign real_diff = ar_br - ai_bi;
    assign imag_sum  = ar_bi + ai_br;

    // Results only load on an accepted pair; otherwise pr/pi hold.
    always_comb begin
        out_valid_d = in_valid;
        pr_d        = pr_q;
        pi_d        = pi_q;
        if (in_valid) begin
            pr_d = real_diff;
            pi_d = imag_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q        <= '0;
            pi_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pr        = pr_q;
    assign pi        = pi_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_complex_multiplier.sv
// ---------------------------------------------------------------------------
// tb_complex_multiplier
//   Self-checking bench: reset checks, a table of hand-computed vectors,
//   a streaming burst, a reset pulse in mid-stream and a randomized run,
//   all compared against a plain 64-bit arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_complex_multiplier;

    typedef struct packed {
        logic [31:0] ar;
        logic [31:0] ai;
        logic [31:0] br;
        logic [31:0] bi;
        logic [63:0] exp_pr;
        logic [63:0] exp_pi;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] ar, ai, br, bi;
    logic [63:0] pr, pi;
    logic        out_valid;

    int          checks   = 0;
    int          failures = 0;

    logic [63:0] exp_pr;
    logic [63:0] exp_pi;
    logic        exp_valid;

    vec_t        vectors [8];
    logic [31:0] s_ar, s_ai, s_br, s_bi;
    logic        s_valid;

    always #5 clk = ~clk;

    complex_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .pr        (pr),
        .pi        (pi),
        .out_valid (out_valid)
    );

    // Reference: complex product with ordinary 64-bit wrapping arithmetic.
    function automatic logic [63:0] ref_real(input logic [31:0] a_r, a_i, b_r, b_i);
        return 64'(a_r) * 64'(b_r) - 64'(a_i) * 64'(b_i);
    endfunction

    function automatic logic [63:0] ref_imag(input logic [31:0] a_r, a_i, b_r, b_i);
        return 64'(a_r) * 64'(b_i) + 64'(a_i) * 64'(b_r);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle of inputs, step past the next rising edge and update
    // the expected output state (load on valid, hold otherwise).
    task automatic applyStimulus(input logic v, input logic [31:0] a_r, a_i, b_r, b_i);
        in_valid = v;
        ar = a_r;
        ai = a_i;
        br = b_r;
        bi = b_i;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            exp_pr = ref_real(a_r, a_i, b_r, b_i);
            exp_pi = ref_imag(a_r, a_i, b_r, b_i);
        end
    endtask

    task automatic checkOutput(input string name);
        checks++;
        if (pr !== exp_pr) begin
            failures++;
            $display("[TB] FAIL %s.pr: got %h, expected %h", name, pr, exp_pr);
        end
        checks++;
        if (pi !== exp_pi) begin
            failures++;
            $display("[TB] FAIL %s.pi: got %h, expected %h", name, pi, exp_pi);
        end
        checks++;
        if (out_valid !== exp_valid) begin
            failures++;
            $display("[TB] FAIL %s.out_valid: got %b, expected %b", name, out_valid, exp_valid);
        end
    endtask

    initial begin
        // Hand-computed vectors, including the documented corner values.
        vectors[0] = '{32'd3, 32'd4, 32'd5, 32'd6,
                       64'hFFFF_FFFF_FFFF_FFF7, 64'd38};
        vectors[1] = '{32'd83, 32'd99, 32'd45, 32'd68,
                       64'd18446744073709548619, 64'd10099};
        vectors[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       64'h0, 64'hFFFF_FFFC_0000_0002};
        vectors[3] = '{32'h0, 32'h0, 32'h0, 32'h0, 64'h0, 64'h0};
        vectors[4] = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0,
                       64'h0000_0000_FFFF_FFFF, 64'h0};
        vectors[5] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0,
                       64'h4000_0000_0000_0000, 64'h0};
        vectors[6] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                       64'h0000_0001_FFFF_FFFF, 64'h0};
        vectors[7] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
                       64'h0, 64'hFFFF_FFFE_0000_0002};

        // Reset with busy inputs: outputs must be zero before any clock.
        rst_n    = 1'b1;
        in_valid = 1'b1;
        ar = 32'd7; ai = 32'd9; br = 32'd11; bi = 32'd13;
        #1 rst_n = 1'b0;
        #1;
        exp_pr = '0; exp_pi = '0; exp_valid = 1'b0;
        checkOutput("reset_async");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_hold%0d", k));
        end
        #2 rst_n = 1'b1;

        // Table: first entry lands on the very first edge after release,
        // and the whole table runs back to back.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, vectors[k].ar, vectors[k].ai, vectors[k].br, vectors[k].bi);
            exp_pr = vectors[k].exp_pr;
            exp_pi = vectors[k].exp_pi;
            checkOutput($sformatf("table%0d", k));
        end

        // Idle cycle: valid drops, results hold.
        applyStimulus(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111, 32'h2222_2222);
        checkOutput("idle_hold");

        // Streaming burst of five pairs, then idle.
        applyStimulus(1'b1, 32'd67483783, 32'd456789999, 32'd568465845, 32'd878976768);
        checkOutput("stream0");
        for (int k = 1; k < 5; k++) begin
            applyStimulus(1'b1, $urandom, $urandom, $urandom, $urandom);
            checkOutput($sformatf("stream%0d", k));
        end
        applyStimulus(1'b0, $urandom, $urandom, $urandom, $urandom);
        checkOutput("stream_idle0");
        applyStimulus(1'b0, $urandom, $urandom, $urandom, $urandom);
        checkOutput("stream_idle1");

        // Reset pulse between two valid pairs; the in-flight pair is lost.
        applyStimulus(1'b1, 32'd1000, 32'd2000, 32'd3000, 32'd4000);
        checkOutput("mid_pre");
        in_valid = 1'b1;
        ar = 32'd55; ai = 32'd66; br = 32'd77; bi = 32'd88;
        #2 rst_n = 1'b0;
        #1;
        exp_pr = '0; exp_pi = '0; exp_valid = 1'b0;
        checkOutput("mid_rst_async");
        @(posedge clk);
        #1;
        checkOutput("mid_rst_hold");
        #3 rst_n = 1'b1;
        applyStimulus(1'b0, 32'd55, 32'd66, 32'd77, 32'd88);
        checkOutput("mid_post_idle");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1357_9BDF);
        checkOutput("mid_post_pair");

        // Randomized traffic with random gaps.
        for (int k = 0; k < 300; k++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_ar = pick_operand();
            s_ai = pick_operand();
            s_br = pick_operand();
            s_bi = pick_operand();
            applyStimulus(s_valid, s_ar, s_ai, s_br, s_bi);
            checkOutput($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
